// File: rtl/stopwatch_timer_core.sv
// BCD minutes/seconds/tenths stopwatch with prescaled tick, preset load, up/down
// mode, lap freeze and a one-cycle Done pulse on terminal count.
module stopwatch_timer_core #(
    parameter int TICK_DIV   = 10_000_000,
    parameter int MIN_DIGITS = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    Start,
    input  logic                    Stop,
    input  logic                    Clear,
    input  logic                    Countdown,
    input  logic                    Lap,
    input  logic                    Load,
    input  logic [4*MIN_DIGITS-1:0] Preset_Minutes,
    input  logic [3:0]              Preset_Tens,
    input  logic [3:0]              Preset_Ones,
    output logic [4*MIN_DIGITS-1:0] Minutes,
    output logic [3:0]              Tens_Seconds,
    output logic [3:0]              Ones_Seconds,
    output logic [3:0]              Tenths_Seconds,
    output logic                    Running,
    output logic                    Lap_Active,
    output logic                    Done,
    output logic [1:0]              dbg_state
);
    localparam int MW = 4 * MIN_DIGITS;
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_t;

    typedef struct packed {
        logic [MW-1:0] mins;
        logic [3:0]    tens;
        logic [3:0]    ones;
        logic [3:0]    tenths;
    } count_t;

    state_t        state, state_n;
    count_t        cnt, cnt_n, snap, snap_n, up_cnt, dn_cnt, preset_cnt;
    logic [PW-1:0] pre, pre_n;
    logic          mode, mode_n;
    logic          lap, lap_n;
    logic          was_done, done_r;
    logic          tick;

    function automatic count_t step_up(input count_t c);
        count_t r;
        logic   carry;
        r     = c;
        carry = 1'b1;
        if (c.tenths >= 4'd9) r.tenths = 4'd0;
        else begin r.tenths = c.tenths + 4'd1; carry = 1'b0; end
        if (carry) begin
            if (c.ones >= 4'd9) r.ones = 4'd0;
            else begin r.ones = c.ones + 4'd1; carry = 1'b0; end
        end
        if (carry) begin
            if (c.tens >= 4'd5) r.tens = 4'd0;
            else begin r.tens = c.tens + 4'd1; carry = 1'b0; end
        end
        for (int i = 0; i < MIN_DIGITS; i++) begin
            if (carry) begin
                if (c.mins[4*i +: 4] >= 4'd9) r.mins[4*i +: 4] = 4'd0;
                else begin r.mins[4*i +: 4] = c.mins[4*i +: 4] + 4'd1; carry = 1'b0; end
            end
        end
        return r;
    endfunction

    function automatic count_t step_down(input count_t c);
        count_t r;
        logic   borrow;
        r      = c;
        borrow = 1'b1;
        if (c.tenths == 4'd0) r.tenths = 4'd9;
        else begin r.tenths = c.tenths - 4'd1; borrow = 1'b0; end
        if (borrow) begin
            if (c.ones == 4'd0) r.ones = 4'd9;
            else begin r.ones = c.ones - 4'd1; borrow = 1'b0; end
        end
        if (borrow) begin
            if (c.tens == 4'd0) r.tens = 4'd5;
            else begin r.tens = c.tens - 4'd1; borrow = 1'b0; end
        end
        for (int i = 0; i < MIN_DIGITS; i++) begin
            if (borrow) begin
                if (c.mins[4*i +: 4] == 4'd0) r.mins[4*i +: 4] = 4'd9;
                else begin r.mins[4*i +: 4] = c.mins[4*i +: 4] - 4'd1; borrow = 1'b0; end
            end
        end
        return r;
    endfunction

    function automatic logic is_max(input count_t c);
        logic m;
        m = (c.tenths == 4'd9) && (c.ones == 4'd9) && (c.tens == 4'd5);
        for (int i = 0; i < MIN_DIGITS; i++) m = m && (c.mins[4*i +: 4] == 4'd9);
        return m;
    endfunction

    always_comb begin
        preset_cnt        = '0;
        for (int i = 0; i < MIN_DIGITS; i++)
            preset_cnt.mins[4*i +: 4] = (Preset_Minutes[4*i +: 4] > 4'd9) ? 4'd9 : Preset_Minutes[4*i +: 4];
        preset_cnt.tens   = (Preset_Tens > 4'd5) ? 4'd5 : Preset_Tens;
        preset_cnt.ones   = (Preset_Ones > 4'd9) ? 4'd9 : Preset_Ones;
        preset_cnt.tenths = 4'd0;
    end

    assign up_cnt = step_up(cnt);
    assign dn_cnt = step_down(cnt);
    assign tick   = (pre == PW'(TICK_DIV - 1));

    // Commands are levels sampled every edge (Clear > Stop > Load > Start); Lap is a one-cycle pulse.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        snap_n  = snap;
        pre_n   = pre;
        mode_n  = mode;
        lap_n   = lap;
        if (Clear) begin
            state_n = IDLE;
            cnt_n   = '0;
            pre_n   = '0;
            lap_n   = 1'b0;
            mode_n  = 1'b0;
        end else begin
            if (Lap && (state == RUN || state == PAUSE)) begin
                lap_n = ~lap;
                if (!lap) snap_n = cnt;
            end
            case (state)
                IDLE: begin
                    if (Stop) begin
                        state_n = IDLE;
                    end else if (Load) begin
                        cnt_n = preset_cnt;
                        pre_n = '0;
                    end else if (Start) begin
                        mode_n  = Countdown;
                        state_n = (Countdown && cnt == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (Stop) begin
                        state_n = PAUSE;
                    end else if (tick) begin
                        pre_n = '0;
                        if (mode) begin
                            // Counting down from an already-zero count terminates instead of wrapping.
                            if (cnt == '0) state_n = DONE;
                            else begin
                                cnt_n = dn_cnt;
                                if (dn_cnt == '0) state_n = DONE;
                            end
                        end else begin
                            cnt_n = up_cnt;
                            if (is_max(up_cnt)) state_n = DONE;
                        end
                    end else begin
                        pre_n = pre + 1'b1;
                    end
                end
                PAUSE: begin
                    if (Stop) begin
                        state_n = PAUSE;
                    end else if (Load) begin
                        cnt_n = preset_cnt;
                        pre_n = '0;
                    end else if (Start) begin
                        state_n = RUN;
                    end
                end
                default: state_n = state;
            endcase
            if (state_n == DONE) lap_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            snap     <= '0;
            pre      <= '0;
            mode     <= 1'b0;
            lap      <= 1'b0;
            was_done <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            snap     <= snap_n;
            pre      <= pre_n;
            mode     <= mode_n;
            lap      <= lap_n;
            was_done <= (state == DONE);
            done_r   <= (state == DONE) && !was_done;
        end
    end

    assign Minutes        = lap ? snap.mins   : cnt.mins;
    assign Tens_Seconds   = lap ? snap.tens   : cnt.tens;
    assign Ones_Seconds   = lap ? snap.ones   : cnt.ones;
    assign Tenths_Seconds = lap ? snap.tenths : cnt.tenths;
    assign Running        = (state == RUN);
    assign Lap_Active     = lap;
    assign Done           = done_r;
    assign dbg_state      = state;
endmodule

// File: tb/tb_stopwatch_timer_core.sv
// Directed bench for stopwatch_timer_core (TICK_DIV=4, one minute digit):
// the driver queues expected displays, a negedge monitor pops and compares them.
module tb_stopwatch_timer_core;
    localparam int W = 29;
    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2, S_DONE = 2'd3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       Start = 1'b0, Stop = 1'b0, Clear = 1'b0, Countdown = 1'b0, Lap = 1'b0, Load = 1'b0;
    logic [3:0] Preset_Minutes = 4'd0, Preset_Tens = 4'd0, Preset_Ones = 4'd0;
    logic [3:0] Minutes, Tens_Seconds, Ones_Seconds, Tenths_Seconds;
    logic       Running, Lap_Active, Done;
    logic [1:0] dbg_state;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           tests = 0;
    int           fails = 0;
    int           dcnt  = 0;

    always #5 clk = ~clk;

    stopwatch_timer_core #(.TICK_DIV(4), .MIN_DIGITS(1)) dut (
        .clk(clk), .reset(reset), .Start(Start), .Stop(Stop), .Clear(Clear),
        .Countdown(Countdown), .Lap(Lap), .Load(Load),
        .Preset_Minutes(Preset_Minutes), .Preset_Tens(Preset_Tens), .Preset_Ones(Preset_Ones),
        .Minutes(Minutes), .Tens_Seconds(Tens_Seconds), .Ones_Seconds(Ones_Seconds),
        .Tenths_Seconds(Tenths_Seconds), .Running(Running), .Lap_Active(Lap_Active),
        .Done(Done), .dbg_state(dbg_state)
    );

    function automatic string fmt(input logic [W-1:0] w);
        return $sformatf("st=%0d run=%b lap=%b done=%b dcnt=%0d disp=%h:%h%h.%h",
                         w[28:27], w[26], w[25], w[24], w[23:16], w[15:12], w[11:8], w[7:4], w[3:0]);
    endfunction

    // Monitor: counts Done pulses, then checks every pending expectation against the current outputs.
    always @(negedge clk) begin
        logic [W-1:0] act, e;
        string        n;
        if (Done === 1'b1) dcnt++;
        act = {dbg_state, Running, Lap_Active, Done, 8'(dcnt),
               Minutes, Tens_Seconds, Ones_Seconds, Tenths_Seconds};
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            tests++;
            if (act !== e) begin
                fails++;
                $display("FAIL %s: got %s, expected %s", n, fmt(act), fmt(e));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_out(input string n, input logic [1:0] st, input logic run, input logic lap,
                              input logic dn, input int dc, input logic [3:0] m, input logic [3:0] t,
                              input logic [3:0] o, input logic [3:0] th);
        exp_q.push_back({st, run, lap, dn, 8'(dc), m, t, o, th});
        name_q.push_back(n);
    endtask

    task automatic load_preset(input logic [3:0] m, input logic [3:0] t, input logic [3:0] o);
        Preset_Minutes = m;
        Preset_Tens    = t;
        Preset_Ones    = o;
        Load = 1'b1;
        cyc(1);
        Load = 1'b0;
    endtask

    task automatic pulse_start();
        Start = 1'b1; cyc(1); Start = 1'b0;
    endtask

    task automatic pulse_clear();
        Clear = 1'b1; cyc(1); Clear = 1'b0;
    endtask

    task automatic pulse_lap();
        Lap = 1'b1; cyc(1); Lap = 1'b0;
    endtask

    initial begin
        // Reset state
        cyc(3);
        expect_out("reset", S_IDLE, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 4'd0);
        reset = 1'b1;

        // One second of counting: 10 ticks of 4 cycles each
        pulse_start();
        cyc(40);
        expect_out("run_1s", S_RUN, 1, 0, 0, 0, 4'd0, 4'd0, 4'd1, 4'd0);

        // Up-count rollover from 0:59 into the minutes
        pulse_clear();
        expect_out("clear_idle", S_IDLE, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 4'd0);
        load_preset(4'd0, 4'd5, 4'd9);
        expect_out("load_059", S_IDLE, 0, 0, 0, 0, 4'd0, 4'd5, 4'd9, 4'd0);
        pulse_start();
        cyc(40);
        expect_out("rollover_100", S_RUN, 1, 0, 0, 0, 4'd1, 4'd0, 4'd0, 4'd0);
        Stop = 1'b1; cyc(1); Stop = 1'b0;
        expect_out("stop_pause", S_PAUSE, 0, 0, 0, 0, 4'd1, 4'd0, 4'd0, 4'd0);
        load_preset(4'd9, 4'd5, 4'd9);
        expect_out("load_in_pause", S_PAUSE, 0, 0, 0, 0, 4'd9, 4'd5, 4'd9, 4'd0);
        pulse_start();
        cyc(35);
        expect_out("near_max", S_RUN, 1, 0, 0, 0, 4'd9, 4'd5, 4'd9, 4'd8);
        cyc(1);
        expect_out("reach_max", S_DONE, 0, 0, 0, 0, 4'd9, 4'd5, 4'd9, 4'd9);
        cyc(1);
        expect_out("max_done_pulse", S_DONE, 0, 0, 1, 1, 4'd9, 4'd5, 4'd9, 4'd9);
        Start = 1'b1; Lap = 1'b1; cyc(1); Lap = 1'b0; cyc(1); Start = 1'b0;
        expect_out("done_held", S_DONE, 0, 0, 0, 1, 4'd9, 4'd5, 4'd9, 4'd9);

        // Countdown from 0:02
        pulse_clear();
        expect_out("clear_from_done", S_IDLE, 0, 0, 0, 1, 4'd0, 4'd0, 4'd0, 4'd0);
        load_preset(4'd0, 4'd0, 4'd2);
        Countdown = 1'b1; Start = 1'b1; cyc(1); Countdown = 1'b0; Start = 1'b0;
        cyc(79);
        expect_out("down_001", S_RUN, 1, 0, 0, 1, 4'd0, 4'd0, 4'd0, 4'd1);
        cyc(1);
        expect_out("down_zero", S_DONE, 0, 0, 0, 1, 4'd0, 4'd0, 4'd0, 4'd0);
        cyc(1);
        expect_out("down_done_pulse", S_DONE, 0, 0, 1, 2, 4'd0, 4'd0, 4'd0, 4'd0);
        pulse_start();
        expect_out("start_in_done", S_DONE, 0, 0, 0, 2, 4'd0, 4'd0, 4'd0, 4'd0);
        pulse_clear();
        expect_out("clear_after_down", S_IDLE, 0, 0, 0, 2, 4'd0, 4'd0, 4'd0, 4'd0);

        // Countdown requested with a zero count
        Countdown = 1'b1; Start = 1'b1; cyc(1); Countdown = 1'b0; Start = 1'b0;
        expect_out("zero_down_done", S_DONE, 0, 0, 0, 2, 4'd0, 4'd0, 4'd0, 4'd0);
        cyc(1);
        expect_out("zero_down_pulse", S_DONE, 0, 0, 1, 3, 4'd0, 4'd0, 4'd0, 4'd0);
        pulse_clear();

        // Lap freeze and release
        pulse_start();
        cyc(140);
        expect_out("run_035", S_RUN, 1, 0, 0, 3, 4'd0, 4'd0, 4'd3, 4'd5);
        pulse_lap();
        expect_out("lap_freeze", S_RUN, 1, 1, 0, 3, 4'd0, 4'd0, 4'd3, 4'd5);
        cyc(47);
        expect_out("lap_still_frozen", S_RUN, 1, 1, 0, 3, 4'd0, 4'd0, 4'd3, 4'd5);
        pulse_lap();
        expect_out("lap_release", S_RUN, 1, 0, 0, 3, 4'd0, 4'd0, 4'd4, 4'd7);

        // Start+Stop together pauses; prescaler phase survives the pause
        Start = 1'b1; Stop = 1'b1; cyc(1); Start = 1'b0; Stop = 1'b0;
        cyc(10);
        expect_out("pause_held", S_PAUSE, 0, 0, 0, 3, 4'd0, 4'd0, 4'd4, 4'd7);
        pulse_start();
        cyc(2);
        expect_out("resume_no_extra", S_RUN, 1, 0, 0, 3, 4'd0, 4'd0, 4'd4, 4'd7);
        cyc(1);
        expect_out("resume_tick", S_RUN, 1, 0, 0, 3, 4'd0, 4'd0, 4'd4, 4'd8);
        cyc(4);
        expect_out("resume_next_tick", S_RUN, 1, 0, 0, 3, 4'd0, 4'd0, 4'd4, 4'd9);
        reset = 1'b0; cyc(1);
        expect_out("reset_mid_run", S_IDLE, 0, 0, 0, 3, 4'd0, 4'd0, 4'd0, 4'd0);
        reset = 1'b1;

        // Load beats Start in IDLE; out-of-range presets saturate
        Start = 1'b1;
        load_preset(4'd1, 4'd2, 4'd3);
        Start = 1'b0;
        expect_out("load_over_start", S_IDLE, 0, 0, 0, 3, 4'd1, 4'd2, 4'd3, 4'd0);
        load_preset(4'hC, 4'd7, 4'hA);
        expect_out("load_saturate", S_IDLE, 0, 0, 0, 3, 4'd9, 4'd5, 4'd9, 4'd0);

        // Reset right after entering DONE suppresses the pending pulse
        pulse_clear();
        Countdown = 1'b1; Start = 1'b1; cyc(1); Countdown = 1'b0; Start = 1'b0;
        expect_out("pre_reset_done", S_DONE, 0, 0, 0, 3, 4'd0, 4'd0, 4'd0, 4'd0);
        reset = 1'b0; cyc(1);
        expect_out("done_suppressed", S_IDLE, 0, 0, 0, 3, 4'd0, 4'd0, 4'd0, 4'd0);
        reset = 1'b1; cyc(1);
        expect_out("no_late_done", S_IDLE, 0, 0, 0, 3, 4'd0, 4'd0, 4'd0, 4'd0);
        cyc(2);

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL queue_drained: got %0d pending, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/stopwatch_timer_core.md
Name: stopwatch_timer_core

Overview:
Parametrised successor to the current stopwatch counter: a BCD minutes/seconds/tenths timer with configurable tick prescaler and minute-digit count. Adds preset load, a latched up/down mode, lap (display freeze), terminal-count detection and a done pulse. Sits between the board button synchronisers and the seven-segment display path. It drives the same Minutes/Tens_Seconds/Ones_Seconds/Tenths_Seconds digit buses into the existing display decoders.

Parameters:
TICK_DIV, 10_000_000, clk cycles per tenth-second tick (>=2)
MIN_DIGITS, 1, number of BCD minute digits (1 or 2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
Start  in  1  level; begin/resume counting
Stop  in  1  level; pause counting
Clear  in  1  level; zero count, return to IDLE
Countdown  in  1  mode select, sampled only on IDLE->RUN
Lap  in  1  single-cycle pulse; toggles display freeze
Load  in  1  load preset (IDLE/PAUSE only)
Preset_Minutes  in  4*MIN_DIGITS  BCD preset minutes
Preset_Tens  in  4  BCD preset tens of seconds (0-5)
Preset_Ones  in  4  BCD preset ones of seconds
Minutes  out  4*MIN_DIGITS  BCD minutes shown
Tens_Seconds  out  4  BCD tens of seconds shown
Ones_Seconds  out  4  BCD ones of seconds shown
Tenths_Seconds  out  4  BCD tenths shown
Running  out  1  high in RUN
Lap_Active  out  1  high while display frozen
Done  out  1  one-cycle pulse on terminal count

Behaviour:
- Reset (reset==0 at clk edge): state IDLE, count all zeros, prescaler 0, mode=up, snapshot zeros, all outputs 0.
- States: IDLE, RUN, PAUSE, DONE. Command priority per cycle: Clear > Stop > Load > Start.
- Clear (any state): count=0, prescaler=0, Lap_Active=0, mode=up, -> IDLE.
- IDLE: Start -> RUN; mode latched from Countdown this cycle. Countdown=1 with count==0 -> DONE, Done=1 next cycle.
- RUN: prescaler increments each cycle; at TICK_DIV-1 it wraps to 0 and issues a tick. Stop -> PAUSE (no tick that cycle). Start, Load and Countdown are ignored.
- PAUSE: prescaler held; Start -> RUN with mode unchanged, prescaler resumes from held value. Load permitted.
- DONE: count held; only Clear or reset exit. Start/Load/Lap are ignored. Lap_Active is forced to 0 on entry.
- Load (IDLE/PAUSE): Minutes/Tens/Ones <= presets, Tenths <= 0, prescaler <= 0. Non-BCD digits (>9, or Tens>5) are saturated to 9/5.
- Tick, up mode: tenths 9->0 carries to ones; ones 9->0 carries to tens; tens 5->0 carries to minutes; minutes are BCD across MIN_DIGITS.
  - Terminal value is all-minute-9s:5:9.9. The tick that reaches it -> DONE.
- Tick, down mode: borrow chain mirrors up mode (tenths 0->9, ones 0->9, tens 0->5, minutes BCD).
  - The tick that reaches 00:00.0 -> DONE.
- Done is registered and asserted for exactly one cycle, the cycle after the state register becomes DONE. It is never asserted otherwise.
- Running = (state==RUN), registered with the state.
- Lap pulse in RUN or PAUSE toggles Lap_Active. On 0->1, the snapshot captures the current count in the same edge. Internal counting continues.
- Digit outputs = Lap_Active ? snapshot : live count. The mux adds no latency: outputs change on the same edge as the count.
- Start and Stop asserted together: Stop wins. Load and Start together in IDLE: Load applied, state stays IDLE.
- Reset mid-RUN: next edge is the full reset state; any pending Done is suppressed.

Test Plan:
- TICK_DIV=4, MIN_DIGITS=1: reset, Start one cycle, run 40 cycles -> 1.0 s shown (Ones=1, Tenths=0), Running=1, Done never asserted.
- Up-count rollover: Load 0:59, Start, 10 ticks -> Minutes=1, Tens=0, Ones=0, Tenths=0. Then run to 9:59.9 -> state DONE, Done high exactly one cycle, count held.
- Countdown: Load 0:02, Countdown=1, Start -> after 20 ticks shows 0:00.0 with one Done pulse. A further Start does nothing; Clear -> IDLE with zeros.
- Countdown from zero: IDLE, count 0, Countdown=1, Start -> DONE, Done pulse on the 2nd edge, count stays 0.
- Lap: run to 0:03.5, Lap pulse -> outputs freeze at 03.5 while the internal count advances. After 12 ticks, Lap again -> outputs jump to 04.7.
- Priority/pause: in RUN assert Start+Stop together -> PAUSE, prescaler held for 10 cycles. Start -> ticks resume with no lost or extra tick. Assert reset mid-RUN -> all outputs 0 on the next edge.
